// File: rtl/uart_tx_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter_if                                         |
// | Description : Request/grant and serializer handshake bundle for          |
// |               uart_tx_arbiter.                                           |
// |   req[NUM_REQ]        level request per requester                        |
// |   data_in[NUM_REQ*8]  requester i byte on bits [8i+7:8i]                 |
// |   grant[NUM_REQ]      one-hot grant pulse, byte captured that cycle      |
// |   tx_load             one-cycle load pulse to the serializer             |
// |   tx_frame[11]        frame presented to the serializer (LSB first)      |
// |   tx_done             completion pulse from the serializer               |
// |   busy                arbiter is not idle                                |
// |   timeout_err         one-cycle pulse on a frame abort                   |
// | Modports    : master = clients + serializer side, slave = arbiter        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data_in;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_load;
  logic [10:0]          tx_frame;
  logic                 tx_done;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req, data_in, tx_done,
    input  grant, tx_load, tx_frame, busy, timeout_err
  );

  modport slave (
    input  req, data_in, tx_done,
    output grant, tx_load, tx_frame, busy, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Round-robin arbiter sharing one UART tx serializer among   |
// |               NUM_REQ byte requesters. Builds the 11-bit frame, pulses   |
// |               tx_load, waits for tx_done (with timeout), then enforces   |
// |               an idle gap before the next arbitration.                   |
// | Ports       : clk   - system clock, rising edge                          |
// |               reset - asynchronous, active-low reset                     |
// |               bus   - uart_tx_arbiter_if.slave (req/data_in/grant,       |
// |                       tx_load/tx_frame/tx_done, busy, timeout_err)       |
// | Options     : UART_TX_PARITY_EN - frame bit9 carries even parity of the  |
// |               data byte; otherwise bit9 is a second stop bit.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input wire clk,
  input wire reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W:0]     NUM_REQ_W    = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]   PTR_LAST     = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GRANT_ONE    = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    LOAD      = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     sel_q;
  logic [PTR_W-1:0]     sel_off;
  logic [PTR_W:0]       sel_sum;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [CNT_W-1:0]     cnt;
  logic [10:0]          frame_q;
  logic [7:0]           byte_sel;
  logic                 bit9;
  logic                 timeout_hit;

  // Rotating the doubled request vector right by rr_ptr puts requester
  // rr_ptr at bit 0, so the lowest set bit is the round-robin winner offset.
  assign req_rot = {bus.req, bus.req} >> rr_ptr;

  always_comb begin
    sel_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_off = PTR_W'(i);
    end
    sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
    sel     = (sel_sum >= NUM_REQ_W) ? PTR_W'(sel_sum - NUM_REQ_W) : PTR_W'(sel_sum);
  end

  assign byte_sel = bus.data_in[{sel_q, 3'b000} +: 8];

`ifdef UART_TX_PARITY_EN
  assign bit9 = ^byte_sel;
`else
  assign bit9 = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (|bus.req) state_nxt = GRANT;
      GRANT:     state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        // A completion arriving on the last allowed cycle beats the timeout.
        if (bus.tx_done) begin
          state_nxt = GAP;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP:       if (cnt == GAP_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      sel_q   <= '0;
      cnt     <= '0;
      frame_q <= 11'h7FF;
    end else begin
      state <= state_nxt;
      // Only the value latched on the IDLE exit cycle is ever used, which
      // freezes the winner against req changes during GRANT.
      if (state == IDLE) sel_q <= sel;
      if (state == GRANT) begin
        frame_q <= {1'b1, bit9, byte_sel, 1'b0};
        rr_ptr  <= (sel_q == PTR_LAST) ? '0 : sel_q + PTR_W'(1);
      end
      // Shared counter restarts on every state change, so WAIT_DONE and GAP
      // both count from zero on entry.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == WAIT_DONE || state == GAP) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.grant       = (state == GRANT) ? (GRANT_ONE << sel_q) : '0;
  assign bus.tx_load     = (state == LOAD);
  assign bus.tx_frame    = frame_q;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = timeout_hit;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Self-checking bench for uart_tx_arbiter. A frame-level     |
// |               reference (round-robin pointer plus expected per-cycle     |
// |               timeline) predicts grant, load, frame, timeout and gap.    |
// | Options     : UART_TX_PARITY_EN selects the expected bit9 encoding.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 3;
  localparam int TMO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic p;
`ifdef UART_TX_PARITY_EN
    p = ^d;
`else
    p = 1'b1;
`endif
    return {1'b1, p, d, 1'b0};
  endfunction

  // First requesting index at or after the model pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // One full frame starting from an IDLE cycle. lat = cycles from tx_load
  // to tx_done (1..TMO), or 0 for a serializer that never answers.
  task automatic do_frame(input logic [N-1:0] r, input logic [31:0] data,
                          input int lat, input bit noisy);
    int          w;
    int          k_end;
    logic [10:0] ef;
    @(negedge clk);
    bus.req = r; bus.data_in = data; bus.tx_done = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_grant", bus.grant, 0);
    w  = pick(r);
    ef = frame_of(data[8*w +: 8]);
    // GRANT cycle
    @(negedge clk);
    if (noisy) begin
      bus.req     = N'($urandom);
      bus.tx_done = 1'($urandom);
    end
    #1;
    chk("grant", bus.grant, 32'(1) << w);
    chk("grant_busy", bus.busy, 1);
    chk("grant_load", bus.tx_load, 0);
    m_ptr = (w + 1) % N;
    // LOAD cycle
    @(negedge clk);
    if (noisy) begin
      bus.tx_done = 1'($urandom);
      bus.data_in = $urandom;
    end
    #1;
    chk("load", bus.tx_load, 1);
    chk("load_grant", bus.grant, 0);
    chk("frame", bus.tx_frame, ef);
    // WAIT_DONE cycles, k counted from the load
    k_end = (lat >= 1 && lat <= TMO) ? lat : TMO;
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      bus.tx_done = (k == lat);
      #1;
      chk("wait_busy", bus.busy, 1);
      chk("wait_load", bus.tx_load, 0);
      chk("timeout_err", bus.timeout_err, (k == TMO && lat != TMO));
    end
    // GAP cycles
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      bus.tx_done = noisy ? 1'($urandom) : 1'b0;
      #1;
      chk("gap_busy", bus.busy, 1);
      chk("gap_grant", bus.grant, 0);
      chk("gap_err", bus.timeout_err, 0);
      chk("frame_hold", bus.tx_frame, ef);
    end
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req     = '0;
      bus.tx_done = 1'($urandom);
      #1;
      chk("idle_noise_busy", bus.busy, 0);
      chk("idle_noise_grant", bus.grant, 0);
    end
  endtask

  task automatic reset_mid_frame();
    @(negedge clk);
    bus.req = 4'b0010; bus.data_in = $urandom; bus.tx_done = 1'b0;
    #1;
    @(negedge clk);
    bus.req = '0;
    #1;
    chk("rst_pre_grant", bus.grant, 4'b0010);
    @(negedge clk);
    #1;
    chk("rst_pre_load", bus.tx_load, 1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_grant", bus.grant, 0);
    chk("rst_async_load", bus.tx_load, 0);
    chk("rst_async_frame", bus.tx_frame, 11'h7FF);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_err", bus.timeout_err, 0);
    @(negedge clk);
    reset       = 1'b1;
    bus.tx_done = 1'b1;
    #1;
    chk("late_done_busy", bus.busy, 0);
    @(negedge clk);
    bus.tx_done = 1'b0;
    #1;
    chk("late_done_busy2", bus.busy, 0);
    chk("late_done_grant", bus.grant, 0);
    m_ptr = 0;
  endtask

  initial begin
    bus.req     = '0;
    bus.data_in = '0;
    bus.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_grant", bus.grant, 0);
    chk("reset_load", bus.tx_load, 0);
    chk("reset_frame", bus.tx_frame, 11'h7FF);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;

    do_frame(4'b0001, 32'h0000_0005, 10, 1'b0);
    for (int i = 0; i < 5; i++) do_frame(4'b1111, $urandom, 10, 1'b0);
    do_frame(4'b1000, $urandom, 4, 1'b0);
    do_frame(4'b0101, $urandom, 4, 1'b0);
    do_frame(4'b0101, $urandom, 4, 1'b0);
    do_frame(4'b0010, $urandom, 0, 1'b0);
    do_frame(4'b0010, $urandom, 3, 1'b0);
    do_frame(4'b0100, $urandom, TMO, 1'b0);
    idle_noise(4);

    for (int i = 0; i < 40; i++) begin
      do_frame(N'($urandom_range(1, 15)), $urandom, $urandom_range(0, TMO), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_noise($urandom_range(1, 3));
    end

    reset_mid_frame();
    do_frame(4'b1111, $urandom, 5, 1'b0);
    do_frame(4'b1111, $urandom, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
